cenn_window_mac: RTL
====================

// Module: cenn_window_mac
// PURPOSE
//  Consumes the three row streams from the line-buffer stage (newest row, row-1, row-2) and builds a 3x3 window.
//  Computes the CeNN feed-forward term y = sum(B[k]*u[k]) + I over that window, in Q6.9 fixed point.
//  Sits between the line buffers and the cell-state integrator.
//  Templates B[0..8] and bias I are runtime-loadable through a simple register write port.
// PARAMETERS
//  WIDTH     15    pixel/coef width, signed two's complement, Q6.9 (1.0 = 15'h0200)
//  FRAC      9     fractional bits of WIDTH
//  LINE_LEN  1024  active pixels per line; column counter wraps here
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      row samples valid this cycle (driven by line-buffer read_ready)
//  row_0      in   WIDTH  newest-line pixel
//  row_1      in   WIDTH  line-1 pixel
//  row_2      in   WIDTH  line-2 pixel
//  coef_we    in   1      coefficient write strobe
//  coef_addr  in   4      0..8 = B[k] (k = 3*r+c; r=0 newest row; c=0 newest column), 9 = I, 10..15 ignored
//  coef_data  in   WIDTH  coefficient value
//  out_valid  out  1      out_pixel valid
//  out_pixel  out  WIDTH  saturated Q6.9 result
//  out_sat    out  1      result was clipped (qualified by out_valid)
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Window regs, pipeline regs, col cleared to 0; out_valid=0, out_pixel=0, out_sat=0.
//   - B[4]=15'h0200; all other B=0; I=0, i.e. identity pass-through of the window centre.
//  Window and column counter
//   - On each edge with in_valid=1, the window shifts one column: column 2 <- column 1 <- column 0 <- {row_0,row_1,row_2}.
//   - col increments on each such edge and wraps LINE_LEN-1 -> 0.
//   - Any cycle with in_valid=0 forces col to 0 (line blanking); window contents are not cleared.
//   - Window is complete when the shift occurs with col>=2 (pre-increment).
//   - No window straddles a line: after a wrap or blanking, the first two samples of each line produce no output.
//  Pipeline (3 stages, each with its own valid bit; drains regardless of in_valid)
//   - S1: nine signed WIDTH x WIDTH products, 2*WIDTH bits each.
//   - S2: sum of the 9 products, 2*WIDTH+4 bits, no overflow possible.
//   - S3: add (I <<< FRAC); arithmetic shift right by FRAC (floor, no rounding).
//     Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; out_sat=1 when clipped.
//   - Latency: a window completed at edge t appears as out_valid=1 at edge t+3.
//   - Sustained throughput is 1 result per clock.
//   - out_pixel and out_sat hold their last value while out_valid=0.
//  Coefficient port
//   - The write lands at the edge where coef_we=1.
//   - S1 products are formed with the coefficient values registered at that edge; the window completing on the same edge still uses the old values.
//   - Writes are legal mid-stream; no pipeline stall or flush.
//   - Addresses 10..15 have no effect.
//  Boundaries
//   - rst_n low mid-line: all state is cleared immediately, including in-flight pipeline data.
//   - The next line starts with a fresh 2-sample fill; coefficients return to identity.
//   - in_valid held high across a LINE_LEN wrap: the first 2 samples of the new line give no output.
// TESTING
//  T1 reset identity: reset; one line of row_1 = k*16 (k=0..LINE_LEN-1), in_valid=1.
//     -> out_valid first at edge 5 after the first sample; out_pixel = row_1 of the centre column, i.e. (k-1)*16; LINE_LEN-2 results.
//  T2 box sum: write B[0..8]=15'h0200, I=0; all rows constant 15'h0200 (1.0).
//     -> out_pixel=15'h1200 (9.0), out_sat=0.
//  T3 saturation: T2 template; rows 15'h3FFF -> out_pixel=15'h3FFF, out_sat=1.
//     Rows 15'h4000 (negative full scale) -> out_pixel=15'h4000, out_sat=1.
//  T4 bias and floor: B=0, I=15'h7FFF (-2^-9) -> out_pixel=15'h7FFF.
//     B[4]=15'h0100 (0.5), row_1=15'h0001 -> 0 (floor of 2^-10).
//  T5 blanking: in_valid high 5 cycles, low 1, high 5 -> exactly 3+3 out_valid pulses.
//     No result mixes samples from both sides of the gap.
//  T6 mid-stream: coef write of B[4] during a line -> results switch on the window completing one edge after the write.
//     rst_n pulse mid-line -> out_valid=0 asynchronously, pipeline empty, identity template restored.

Source files
------------

// File: rtl/cenn_window_mac.sv
// cenn_window_mac: builds a 3x3 window from three row streams and computes y = sum(B*u) + I in saturated Q6.9.
// The window register feeds a three-stage pipeline: products, adder tree, then bias/shift/saturate.
module cenn_window_mac #(
   parameter int WIDTH    = 15,
   parameter int FRAC     = 9,
   parameter int LINE_LEN = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] row_0,
   input  logic [WIDTH-1:0] row_1,
   input  logic [WIDTH-1:0] row_2,
   input  logic             coef_we,
   input  logic [3:0]       coef_addr,
   input  logic [WIDTH-1:0] coef_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pixel,
   output logic             out_sat
);
   localparam int PW = 2*WIDTH;
   localparam int SW = 2*WIDTH + 4;
   localparam int CW = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 2;
   localparam logic signed [SW:0] MAX_V = (SW+1)'((1 << (WIDTH-1)) - 1);
   localparam logic signed [SW:0] MIN_V = -MAX_V - 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

   logic signed [WIDTH-1:0] row [3];
   logic signed [WIDTH-1:0] win_q [9], win_d [9];
   logic signed [WIDTH-1:0] b_q [9], b_d [9], bd_q [9], bd_d [9];
   logic signed [WIDTH-1:0] i_q, i_d;
   logic signed [PW-1:0]    prod_q [9], prod_d [9];
   logic signed [SW-1:0]    sum_q, sum_d;
   logic signed [SW:0]      acc, shr;
   logic [CW-1:0]           col_q, col_d;
   logic                    win_v_q, win_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic                    out_valid_q, out_valid_d, out_sat_q, out_sat_d, hi, lo;
   logic [WIDTH-1:0]        out_pixel_q, out_pixel_d;

   // Window index is 3*r+c; c=0 is the newest column. bd_q lags b_q by one edge so a
   // window completing on the write edge still multiplies with the previous template.
   always_comb begin
      row[0] = row_0;
      row[1] = row_1;
      row[2] = row_2;
      for (int r = 0; r < 3; r++) begin
         win_d[3*r]   = in_valid ? row[r]       : win_q[3*r];
         win_d[3*r+1] = in_valid ? win_q[3*r]   : win_q[3*r+1];
         win_d[3*r+2] = in_valid ? win_q[3*r+1] : win_q[3*r+2];
      end
      col_d   = !in_valid ? '0 : (col_q == CW'(LINE_LEN-1)) ? '0 : col_q + CW'(1);
      win_v_d = in_valid && (col_q >= CW'(2));
      for (int k = 0; k < 9; k++) begin
         b_d[k]    = (coef_we && coef_addr == 4'(k)) ? coef_data : b_q[k];
         bd_d[k]   = b_q[k];
         prod_d[k] = PW'(win_q[k]) * PW'(bd_q[k]);
      end
      i_d    = (coef_we && coef_addr == 4'd9) ? coef_data : i_q;
      s1_v_d = win_v_q;
      sum_d  = '0;
      for (int k = 0; k < 9; k++) sum_d = sum_d + SW'(prod_q[k]);
      s2_v_d      = s1_v_q;
      acc         = (SW+1)'(sum_q) + ((SW+1)'(i_q) <<< FRAC);
      shr         = acc >>> FRAC;
      hi          = shr > MAX_V;
      lo          = shr < MIN_V;
      out_valid_d = s2_v_q;
      out_pixel_d = !s2_v_q ? out_pixel_q : hi ? MAX_V[WIDTH-1:0] : lo ? MIN_V[WIDTH-1:0] : shr[WIDTH-1:0];
      out_sat_d   = s2_v_q ? (hi || lo) : out_sat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            win_q[k]  <= '0;
            b_q[k]    <= (k == 4) ? ONE : '0;
            bd_q[k]   <= (k == 4) ? ONE : '0;
            prod_q[k] <= '0;
         end
         i_q         <= '0;
         sum_q       <= '0;
         col_q       <= '0;
         win_v_q     <= 1'b0;
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         for (int k = 0; k < 9; k++) begin
            win_q[k]  <= win_d[k];
            b_q[k]    <= b_d[k];
            bd_q[k]   <= bd_d[k];
            prod_q[k] <= prod_d[k];
         end
         i_q         <= i_d;
         sum_q       <= sum_d;
         col_q       <= col_d;
         win_v_q     <= win_v_d;
         s1_v_q      <= s1_v_d;
         s2_v_q      <= s2_v_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_sat   = out_sat_q;
endmodule
